// File: rtl/hour_counter.sv
// Hour-of-day register (0..23) with edge-triggered advance, manual set, BCD display digits and day rollover.
// Optional hourly chime pulse built only when HOUR_CHIME_EN is defined.
module hour_counter #(
    parameter int RESET_HOUR   = 12,
    parameter int CHIME_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hour_enable,
    input  logic       set_mode,
    input  logic       set_inc,
    input  logic       set_dec,
    input  logic       mode_12h,
    output logic [4:0] hour24,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic       pm,
    output logic       day_wrap,
    output logic       chime
);

    logic en_q;
    logic adv;
    logic auto_adv;

    function automatic logic [4:0] hour_inc(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [4:0] hour_dec(input logic [4:0] h);
        return (h == 5'd0) ? 5'd23 : h - 5'd1;
    endfunction

    assign adv      = hour_enable & ~en_q;
    assign auto_adv = adv & ~set_mode;

    // en_q resets high so a level held through reset is not seen as a fresh rise
    always_ff @(posedge clk) begin
        if (reset) begin
            hour24   <= 5'(RESET_HOUR);
            en_q     <= 1'b1;
            day_wrap <= 1'b0;
        end else begin
            en_q     <= hour_enable;
            day_wrap <= 1'b0;
            if (set_mode) begin
                if (set_inc && !set_dec)
                    hour24 <= hour_inc(hour24);
                else if (set_dec && !set_inc)
                    hour24 <= hour_dec(hour24);
            end else if (adv) begin
                hour24   <= hour_inc(hour24);
                day_wrap <= (hour24 == 5'd23);
            end
        end
    end

    logic [4:0] disp;

    always_comb begin
        disp      = hour24;
        hour_tens = 4'd0;
        hour_ones = 4'd0;
        if (mode_12h) begin
            if (hour24 == 5'd0)
                disp = 5'd12;
            else if (hour24 > 5'd12)
                disp = hour24 - 5'd12;
        end
        if (disp >= 5'd20) begin
            hour_tens = 4'd2;
            hour_ones = 4'(disp - 5'd20);
        end else if (disp >= 5'd10) begin
            hour_tens = 4'd1;
            hour_ones = 4'(disp - 5'd10);
        end else begin
            hour_ones = 4'(disp);
        end
    end

    assign pm = (hour24 >= 5'd12);

`ifdef HOUR_CHIME_EN
    localparam int CW = (CHIME_CYCLES > 1) ? $clog2(CHIME_CYCLES) : 1;

    logic [CW-1:0] chime_cnt;

    // chime_cnt holds the remaining high cycles after the current one
    always_ff @(posedge clk) begin
        if (reset) begin
            chime     <= 1'b0;
            chime_cnt <= '0;
        end else if (auto_adv) begin
            chime     <= 1'b1;
            chime_cnt <= CW'(CHIME_CYCLES - 1);
        end else if (chime) begin
            if (chime_cnt == '0)
                chime <= 1'b0;
            else
                chime_cnt <= chime_cnt - 1'b1;
        end
    end
`else
    logic unused_chime_cfg;

    assign chime            = 1'b0;
    assign unused_chime_cfg = auto_adv ^ (CHIME_CYCLES == 0);
`endif

endmodule

// File: tb/tb_hour_counter.sv
// Directed bench for hour_counter: vector table for set/display behaviour plus hand sequences
// for reset, rollover, held enable and the optional chime.
module tb_hour_counter;

    logic       clk = 1'b0;
    logic       reset, hour_enable, set_mode, set_inc, set_dec, mode_12h;
    logic [4:0] hour24;
    logic [3:0] hour_tens, hour_ones;
    logic       pm, day_wrap, chime;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hour_counter #(.RESET_HOUR(12), .CHIME_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .hour_enable(hour_enable), .set_mode(set_mode),
        .set_inc(set_inc), .set_dec(set_dec), .mode_12h(mode_12h), .hour24(hour24),
        .hour_tens(hour_tens), .hour_ones(hour_ones), .pm(pm), .day_wrap(day_wrap),
        .chime(chime)
    );

    typedef struct {
        logic       sm, inc, dec, hen, m12;
        logic [4:0] h24;
        logic [3:0] tens, ones;
        logic       pm, wrap;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int h, input int t, input int o,
                           input int p, input int w);
        chk({name, ".hour24"}, int'(hour24), h);
        chk({name, ".tens"}, int'(hour_tens), t);
        chk({name, ".ones"}, int'(hour_ones), o);
        chk({name, ".pm"}, int'(pm), p);
        chk({name, ".day_wrap"}, int'(day_wrap), w);
    endtask

    initial begin
        //         sm   inc  dec  hen  m12   h24    tens  ones  pm   wrap
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 5'd13, 4'd0, 4'd1, 1'b1,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 5'd13, 4'd1, 4'd3, 1'b1,1'b0};
        vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 5'd13, 4'd1, 4'd3, 1'b1,1'b0};
        vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b1, 5'd12, 4'd1, 4'd2, 1'b1,1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b1, 5'd11, 4'd1, 4'd1, 1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 5'd11, 4'd1, 4'd1, 1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd12, 4'd1, 4'd2, 1'b1,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 5'd12, 4'd1, 4'd2, 1'b1,1'b0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1, 5'd12, 4'd1, 4'd2, 1'b1,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 5'd12, 4'd1, 4'd2, 1'b1,1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 5'd12, 4'd1, 4'd2, 1'b1,1'b0};
        vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 5'd12, 4'd1, 4'd2, 1'b1,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 5'd13, 4'd0, 4'd1, 1'b1,1'b0};

        reset = 1'b1; hour_enable = 1'b1; set_mode = 1'b0;
        set_inc = 1'b0; set_dec = 1'b0; mode_12h = 1'b1;
        tick(); tick();
        chk_all("reset", 12, 1, 2, 1, 0);
        chk("reset.chime", int'(chime), 0);
        chk("reset.legal_range", int'(hour24 <= 5'd23), 1);

        // enable held high across reset release must not advance
        reset = 1'b0;
        tick();
        chk("held_through_reset", int'(hour24), 12);
        hour_enable = 1'b0;
        tick();
        chk("after_release", int'(hour24), 12);

        for (int i = 0; i < 13; i++) begin
            set_mode = vecs[i].sm; set_inc = vecs[i].inc; set_dec = vecs[i].dec;
            hour_enable = vecs[i].hen; mode_12h = vecs[i].m12;
            tick();
            set_inc = 1'b0; set_dec = 1'b0;
            chk_all($sformatf("vec%0d", i), int'(vecs[i].h24), int'(vecs[i].tens),
                    int'(vecs[i].ones), int'(vecs[i].pm), int'(vecs[i].wrap));
        end

        // 13 -> 22 via manual increments
        set_mode = 1'b1; hour_enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_inc = 1'b1; tick();
            set_inc = 1'b0; tick();
        end
        set_mode = 1'b0; mode_12h = 1'b1;
        tick();
        chk("preset22", int'(hour24), 22);

        hour_enable = 1'b1; tick();
        chk_all("adv23", 23, 1, 1, 1, 0);
        hour_enable = 1'b0; tick();
        hour_enable = 1'b1; tick();
        chk_all("wrap0", 0, 1, 2, 0, 1);
        hour_enable = 1'b0; tick();
        chk_all("wrap_end", 0, 1, 2, 0, 0);

        // manual set at the 0/23 boundary
        set_mode = 1'b1; mode_12h = 1'b0;
        set_dec = 1'b1; tick(); set_dec = 1'b0;
        chk_all("set_dec_wrap", 23, 2, 3, 1, 0);
        set_inc = 1'b1; set_dec = 1'b1; tick(); set_inc = 1'b0; set_dec = 1'b0;
        chk("inc_dec_both", int'(hour24), 23);
        hour_enable = 1'b1; tick();
        chk("adv_in_set_mode", int'(hour24), 23);
        set_mode = 1'b0; tick();
        chk("no_deferred_adv", int'(hour24), 23);
        chk("no_deferred_wrap", int'(day_wrap), 0);
        hour_enable = 1'b0; tick(); tick(); tick(); tick(); tick();

        // held enable: exactly one step, visible one cycle after the rise
        hour_enable = 1'b1; tick();
        chk("hold_first", int'(hour24), 0);
        chk("hold_wrap", int'(day_wrap), 1);
        begin
            int bad = 0;
            for (int i = 0; i < 49; i++) begin
                tick();
                if (hour24 != 5'd0 || day_wrap != 1'b0) bad++;
            end
            chk("hold_50_bad_cycles", bad, 0);
        end
        hour_enable = 1'b0; tick();

`ifdef HOUR_CHIME_EN
        chk("chime_idle", int'(chime), 0);
        hour_enable = 1'b1; tick();
        chk("chime_adv_hour", int'(hour24), 1);
        chk("chime_c1", int'(chime), 1);
        hour_enable = 1'b0;
        tick(); chk("chime_c2", int'(chime), 1);
        tick(); chk("chime_c3", int'(chime), 1);
        tick(); chk("chime_c4", int'(chime), 1);
        tick(); chk("chime_c5_off", int'(chime), 0);

        set_mode = 1'b1; set_inc = 1'b1; tick(); set_inc = 1'b0;
        chk("chime_set_inc", int'(chime), 0);
        set_mode = 1'b0; tick();

        hour_enable = 1'b1; tick();
        chk("chime_r1", int'(chime), 1);
        hour_enable = 1'b0; tick();
        chk("chime_r2", int'(chime), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("chime_reset", int'(chime), 0);
        chk("chime_reset_hour", int'(hour24), 12);
`else
        hour_enable = 1'b1; tick();
        chk("adv_hour", int'(hour24), 1);
        chk("chime_tied_c1", int'(chime), 0);
        hour_enable = 1'b0; tick();
        chk("chime_tied_c2", int'(chime), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
